// File: rtl/salamander_romreq_arbiter_if.sv
// Requester and external-memory signals of the Salamander ROM request arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the memory.
interface salamander_romreq_arbiter_if;
  logic [15:0] i_PROG_ADDR;
  logic        i_PROG_RDRQ;
  logic [16:0] i_DATA_ADDR;
  logic        i_DATA_RDRQ;
  logic [14:0] i_SND_ADDR;
  logic        i_SND_RDRQ;
  logic [15:0] o_PROG_DATA;
  logic [15:0] o_DATA_DATA;
  logic [15:0] o_SND_DATA;
  logic        o_PROG_RDY;
  logic        o_DATA_RDY;
  logic        o_SND_RDY;
  logic [21:0] o_MEM_ADDR;
  logic        o_MEM_RD;
  logic        i_MEM_ACK;
  logic [15:0] i_MEM_DATA;
  logic        o_BUSY;
  logic        o_TMO_ERR;

  modport master (
    input  i_PROG_ADDR, i_PROG_RDRQ, i_DATA_ADDR, i_DATA_RDRQ, i_SND_ADDR, i_SND_RDRQ,
    input  i_MEM_ACK, i_MEM_DATA,
    output o_PROG_DATA, o_DATA_DATA, o_SND_DATA, o_PROG_RDY, o_DATA_RDY, o_SND_RDY,
    output o_MEM_ADDR, o_MEM_RD, o_BUSY, o_TMO_ERR
  );

  modport slave (
    output i_PROG_ADDR, i_PROG_RDRQ, i_DATA_ADDR, i_DATA_RDRQ, i_SND_ADDR, i_SND_RDRQ,
    output i_MEM_ACK, i_MEM_DATA,
    input  o_PROG_DATA, o_DATA_DATA, o_SND_DATA, o_PROG_RDY, o_DATA_RDY, o_SND_RDY,
    input  o_MEM_ADDR, o_MEM_RD, o_BUSY, o_TMO_ERR
  );
endinterface

// File: rtl/salamander_romreq_arbiter.sv
// Three single-word cached ROM requesters sharing one external read port.
// Fixed priority PROG > DATA > SND, with an acknowledge timeout that fills 16'hFFFF.
module salamander_romreq_arbiter #(
  parameter logic [21:0] PROG_BASE = 22'h000000,
  parameter logic [21:0] DATA_BASE = 22'h010000,
  parameter logic [21:0] SND_BASE  = 22'h030000,
  parameter logic [7:0]  TMO_CYC   = 8'd255
) (
  input logic i_EMU_MCLK,
  input logic i_EMU_INITRST_n,
  salamander_romreq_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e      state_q;
  logic [15:0] progTag_q;
  logic [16:0] dataTag_q;
  logic [14:0] sndTag_q;
  logic [15:0] progData_q;
  logic [15:0] dataData_q;
  logic [15:0] sndData_q;
  logic [2:0]  valid_q;
  logic [1:0]  grant_q;
  logic [1:0]  grant_d;
  logic [16:0] addrLat_q;
  logic [16:0] addrLat_d;
  logic [21:0] memAddr_q;
  logic [21:0] memAddr_d;
  logic        memRd_q;
  logic        tmoErr_q;
  logic [7:0]  cnt_q;
  logic [2:0]  hit;
  logic [2:0]  need;
  logic        waitDone;
  logic [15:0] fillWord;

  assign hit[0] = valid_q[0] && (progTag_q == bus.i_PROG_ADDR);
  assign hit[1] = valid_q[1] && (dataTag_q == bus.i_DATA_ADDR);
  assign hit[2] = valid_q[2] && (sndTag_q == bus.i_SND_ADDR);
  assign need   = {bus.i_SND_RDRQ, bus.i_DATA_RDRQ, bus.i_PROG_RDRQ} & ~hit;

  // Ack always wins over a timeout landing on the same cycle.
  assign waitDone = bus.i_MEM_ACK || (cnt_q == TMO_CYC);
  assign fillWord = bus.i_MEM_ACK ? bus.i_MEM_DATA : 16'hFFFF;

  always_comb begin
    grant_d   = 2'd0;
    addrLat_d = {1'b0, bus.i_PROG_ADDR};
    memAddr_d = PROG_BASE + {6'b0, bus.i_PROG_ADDR};
    if (need[0]) begin
      grant_d   = 2'd0;
      addrLat_d = {1'b0, bus.i_PROG_ADDR};
      memAddr_d = PROG_BASE + {6'b0, bus.i_PROG_ADDR};
    end else if (need[1]) begin
      grant_d   = 2'd1;
      addrLat_d = bus.i_DATA_ADDR;
      memAddr_d = DATA_BASE + {5'b0, bus.i_DATA_ADDR};
    end else if (need[2]) begin
      grant_d   = 2'd2;
      addrLat_d = {2'b0, bus.i_SND_ADDR};
      memAddr_d = SND_BASE + {7'b0, bus.i_SND_ADDR};
    end
  end

  // The strobe and address are registered on the way into ISSUE so they appear during ISSUE.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_q    <= IDLE;
      progTag_q  <= '0;
      dataTag_q  <= '0;
      sndTag_q   <= '0;
      progData_q <= 16'hFFFF;
      dataData_q <= 16'hFFFF;
      sndData_q  <= 16'hFFFF;
      valid_q    <= '0;
      grant_q    <= '0;
      addrLat_q  <= '0;
      memAddr_q  <= '0;
      memRd_q    <= 1'b0;
      tmoErr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|need) begin
            grant_q   <= grant_d;
            addrLat_q <= addrLat_d;
            memAddr_q <= memAddr_d;
            memRd_q   <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          memRd_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (waitDone) begin
            case (grant_q)
              2'd0: begin
                progData_q <= fillWord;
                progTag_q  <= addrLat_q[15:0];
                valid_q[0] <= 1'b1;
              end
              2'd1: begin
                dataData_q <= fillWord;
                dataTag_q  <= addrLat_q;
                valid_q[1] <= 1'b1;
              end
              default: begin
                sndData_q  <= fillWord;
                sndTag_q   <= addrLat_q[14:0];
                valid_q[2] <= 1'b1;
              end
            endcase
            if (!bus.i_MEM_ACK) begin
              tmoErr_q <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_PROG_DATA = progData_q;
  assign bus.o_DATA_DATA = dataData_q;
  assign bus.o_SND_DATA  = sndData_q;
  assign bus.o_PROG_RDY  = bus.i_PROG_RDRQ && hit[0];
  assign bus.o_DATA_RDY  = bus.i_DATA_RDRQ && hit[1];
  assign bus.o_SND_RDY   = bus.i_SND_RDRQ && hit[2];
  assign bus.o_MEM_ADDR  = memAddr_q;
  assign bus.o_MEM_RD    = memRd_q;
  assign bus.o_BUSY      = (state_q != IDLE);
  assign bus.o_TMO_ERR   = tmoErr_q;

endmodule

// File: doc/salamander_romreq_arbiter.md
SALAMANDER_ROMREQ_ARBITER -- requirements
Module: salamander_romreq_arbiter

Interface
REQ-001 SHALL have parameter PROG_BASE, default 22'h000000, word base of program ROM in external memory.
REQ-002 SHALL have parameter DATA_BASE, default 22'h010000, word base of data ROM.
REQ-003 SHALL have parameter SND_BASE, default 22'h030000, word base of sound ROM.
REQ-004 SHALL have parameter TMO_CYC, default 8'd255, cycles allowed for memory acknowledge.
REQ-005 i_EMU_MCLK  in  1  single clock; all state updates on its rising edge.
REQ-006 i_EMU_INITRST_n  in  1  reset, asynchronous, active-low.
REQ-007 i_PROG_ADDR  in  16  program ROM word address; i_PROG_RDRQ  in  1  level read request.
REQ-008 i_DATA_ADDR  in  17  data ROM word address; i_DATA_RDRQ  in  1  level read request.
REQ-009 i_SND_ADDR  in  15  sound ROM word address; i_SND_RDRQ  in  1  level read request.
REQ-010 o_PROG_DATA / o_DATA_DATA / o_SND_DATA  out  16 each  last fetched word per requester.
REQ-011 o_PROG_RDY / o_DATA_RDY / o_SND_RDY  out  1 each  requested word valid on data output.
REQ-012 o_MEM_ADDR  out  22  external word address; o_MEM_RD  out  1  one-cycle read strobe.
REQ-013 i_MEM_ACK  in  1  one-cycle acknowledge; i_MEM_DATA  in  16  valid when i_MEM_ACK high.
REQ-014 o_BUSY  out  1  transaction outstanding; o_TMO_ERR  out  1  sticky timeout flag.

Function
REQ-015 SHALL keep per requester a tag register (address of held word) and a valid bit.
REQ-016 Hit SHALL be valid AND tag equal to the current address; RDY SHALL be RDRQ AND hit, combinational from registers.
REQ-017 A requester needs a fetch when RDRQ=1 and hit=0.
REQ-018 FSM states: IDLE, ISSUE, WAIT.
REQ-019 IDLE: if any requester needs a fetch, grant by fixed priority PROG > DATA > SND, latch grant and address, go to ISSUE; otherwise stay.
REQ-020 ISSUE: o_MEM_RD=1 for exactly this cycle, o_MEM_ADDR = base + zero-extended latched address (22-bit add, carry discarded), then go to WAIT.
REQ-021 o_MEM_ADDR SHALL hold the latched value from ISSUE through WAIT.
REQ-022 WAIT: on i_MEM_ACK, load i_MEM_DATA into granted data register, tag := latched address, valid := 1, go to IDLE.
REQ-023 Minimum fetch latency: RDRQ rising with miss -> RDY high 3 cycles after ACK-in-first-WAIT-cycle (IDLE, ISSUE, WAIT, RDY next).
REQ-024 i_MEM_ACK outside WAIT SHALL be ignored.
REQ-025 WAIT counter SHALL count cycles from 0; at count = TMO_CYC without ACK: data register := 16'hFFFF, tag := latched address, valid := 1, o_TMO_ERR := 1, go to IDLE.
REQ-026 o_TMO_ERR SHALL clear only on reset.
REQ-027 Address change of the granted requester during ISSUE/WAIT SHALL NOT abort the fetch; the completed word is stored with the old tag, RDY stays low, refetch follows from IDLE.
REQ-028 RDRQ deassertion SHALL NOT clear valid or tag; reasserting with the same address hits with no memory access.
REQ-029 Simultaneous ACK and timeout in the same cycle: ACK SHALL win, o_TMO_ERR unchanged.
REQ-030 o_BUSY SHALL be 1 in ISSUE and WAIT, 0 in IDLE.
REQ-031 Non-granted requesters SHALL keep their data registers and RDY unchanged while another fetch runs.

Reset
REQ-032 Reset assertion SHALL immediately force: FSM=IDLE, o_MEM_RD=0, o_MEM_ADDR=0, o_BUSY=0, o_TMO_ERR=0, all valid=0, all tags=0, all data registers=16'hFFFF, counter=0.
REQ-033 Reset mid-transaction SHALL drop the fetch; a late i_MEM_ACK after release SHALL be ignored (FSM in IDLE).

Verification
REQ-034 PROG_RDRQ=1, addr 16'h0123, ACK with 16'hBEEF 2 cycles after strobe -> o_MEM_ADDR=22'h000123, one o_MEM_RD pulse, o_PROG_DATA=16'hBEEF, o_PROG_RDY=1.
REQ-035 PROG and SND request same cycle (SND addr 15'h0010) -> PROG served first, then o_MEM_ADDR=22'h030010; o_PROG_RDY stays 1 during SND fetch.
REQ-036 Drop and reassert DATA_RDRQ at addr 17'h1FFFF after fetch -> RDY in same cycle, no o_MEM_RD; addr 17'h00000 -> new fetch at 22'h010000.
REQ-037 No ACK for 255 WAIT cycles -> data 16'hFFFF, RDY=1, o_TMO_ERR=1, persists through later good fetches.
REQ-038 Change PROG addr 16'h0001->16'h0002 during WAIT -> first word stored, RDY low, second strobe at 22'h000002, then RDY=1.
REQ-039 Assert reset in WAIT, release, pulse i_MEM_ACK -> all outputs at reset values, no data capture.
